// File: rtl/aes_enc_round_pipe_if.sv
// Handshake and data bundle for the AES forward round pipeline: upstream
// state/key transfer on one side, round result and completed-block count on the other.
interface aes_enc_round_pipe_if #(
  parameter int CNT_W = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [127:0]     state_in;
  logic [127:0]     round_key;
  logic             last_round;
  logic             out_valid;
  logic             out_ready;
  logic [127:0]     state_out;
  logic [CNT_W-1:0] blk_count;

  modport master (
    output in_valid, state_in, round_key, last_round, out_ready,
    input  in_ready, out_valid, state_out, blk_count
  );

  modport slave (
    input  in_valid, state_in, round_key, last_round, out_ready,
    output in_ready, out_valid, state_out, blk_count
  );
endinterface

// File: rtl/aes_enc_round_pipe.sv
// Forward AES round (ShiftRows, MixColumns, AddRoundKey) as a two-stage
// valid/ready pipeline; SubBytes has already been applied upstream.
module aes_enc_round_pipe #(
  parameter int CNT_W = 16
) (
  input logic                clk,
  input logic                rst_n,
  aes_enc_round_pipe_if.slave bus
);

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Row r lives in bits [32r+31:32r]; column 0 is the MSB byte of each row word.
  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        o[32*r+31-8*c -: 8] = s[32*r+31-8*((c+r)%4) -: 8];
      end
    end
    return o;
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[31-8*c  -: 8];
      a1 = s[63-8*c  -: 8];
      a2 = s[95-8*c  -: 8];
      a3 = s[127-8*c -: 8];
      o[31-8*c  -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
      o[63-8*c  -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
      o[95-8*c  -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
      o[127-8*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end
    return o;
  endfunction

  logic [127:0]     sr_p1;
  logic [127:0]     key_p1;
  logic             last_p1;
  logic             vld_p1;
  logic [127:0]     out_p2;
  logic             vld_p2;
  logic [CNT_W-1:0] cnt_p2;

  logic             s2_load;
  logic             adv_p1;
  logic             xfer_p0;
  logic             done_p2;
  logic [127:0]     round_p1;

  assign s2_load  = !vld_p2 || bus.out_ready;
  assign adv_p1   = vld_p1 && s2_load;
  assign xfer_p0  = bus.in_valid && bus.in_ready;
  assign done_p2  = vld_p2 && bus.out_ready;
  assign round_p1 = (last_p1 ? sr_p1 : mix_columns(sr_p1)) ^ key_p1;

  assign bus.in_ready  = !vld_p1 || s2_load;
  assign bus.out_valid = vld_p2;
  assign bus.state_out = out_p2;
  assign bus.blk_count = cnt_p2;

  // ---- stage p0 -> p1: ShiftRows and key capture (data not reset) ----
  always_ff @(posedge clk) begin
    if (xfer_p0) begin
      sr_p1   <= shift_rows(bus.state_in);
      key_p1  <= bus.round_key;
      last_p1 <= bus.last_round;
    end
  end

  // ---- stage p1 -> p2: MixColumns/AddRoundKey, valid flags and counter ----
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_p1 <= 1'b0;
      vld_p2 <= 1'b0;
      out_p2 <= '0;
      cnt_p2 <= '0;
    end else begin
      if (xfer_p0) begin
        vld_p1 <= 1'b1;
      end else if (adv_p1) begin
        vld_p1 <= 1'b0;
      end
      // An empty S1 on a free S2 leaves a bubble, which is how delivered results retire.
      if (s2_load) begin
        vld_p2 <= vld_p1;
      end
      if (adv_p1) begin
        out_p2 <= round_p1;
      end
      if (done_p2) begin
        cnt_p2 <= cnt_p2 + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_aes_enc_round_pipe.sv
// Directed bench for aes_enc_round_pipe: hand-computed round vectors,
// latency, backpressure, full-rate streaming and mid-stream reset.
module tb_aes_enc_round_pipe;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  int   exp_cnt;

  aes_enc_round_pipe_if #(.CNT_W(16)) bus ();

  aes_enc_round_pipe #(.CNT_W(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic send_one(input string tag, input logic [127:0] st, input logic [127:0] key,
                          input logic last, input logic [127:0] exp);
    bus.state_in   = st;
    bus.round_key  = key;
    bus.last_round = last;
    bus.in_valid   = 1'b1;
    bus.out_ready  = 1'b1;
    #1;
    check({tag, "_in_ready"}, 128'(bus.in_ready), 128'd1);
    tick;
    bus.in_valid = 1'b0;
    check({tag, "_not_yet"}, 128'(bus.out_valid), 128'd0);
    tick;
    check({tag, "_out_valid"}, 128'(bus.out_valid), 128'd1);
    check({tag, "_state"}, bus.state_out, exp);
    tick;
    exp_cnt++;
    check({tag, "_count"}, 128'(bus.blk_count), 128'(exp_cnt));
    check({tag, "_drained"}, 128'(bus.out_valid), 128'd0);
  endtask

  logic [127:0] bp[4];
  logic [127:0] tp_exp[8];
  logic [7:0]   k;
  int           sent;
  int           rcv;
  logic         acc;
  logic         con;

  initial begin
    checks  = 0;
    errors  = 0;
    exp_cnt = 0;
    rst_n          = 1'b0;
    bus.in_valid   = 1'b0;
    bus.state_in   = '0;
    bus.round_key  = '0;
    bus.last_round = 1'b0;
    bus.out_ready  = 1'b0;
    tick;
    tick;

    check("rst_out_valid", 128'(bus.out_valid), 128'd0);
    check("rst_state_out", bus.state_out, 128'd0);
    check("rst_blk_count", 128'(bus.blk_count), 128'd0);
    check("rst_in_ready", 128'(bus.in_ready), 128'd1);
    rst_n = 1'b1;
    tick;

    send_one("mixcol", 128'h45454545_53535353_13131313_dbdbdbdb, 128'd0, 1'b0,
             128'hbcbcbcbc_a1a1a1a1_4d4d4d4d_8e8e8e8e);
    send_one("shiftrows", 128'h30313233_20212223_10111213_00010203, 128'd0, 1'b1,
             128'h33303132_22232021_11121310_00010203);
    send_one("key_mix", {16{8'hc6}}, {16{8'hff}}, 1'b0, {16{8'h39}});

    // Backpressure: uniform rows make ShiftRows the identity, so output equals input.
    bp[0] = {16{8'h11}};
    bp[1] = {16{8'h22}};
    bp[2] = {16{8'h33}};
    bp[3] = {16{8'h44}};
    bus.round_key  = '0;
    bus.last_round = 1'b1;
    bus.out_ready  = 1'b0;
    bus.in_valid   = 1'b1;
    bus.state_in   = bp[0];
    #1;
    check("bp_ready0", 128'(bus.in_ready), 128'd1);
    tick;
    bus.state_in = bp[1];
    #1;
    check("bp_ready1", 128'(bus.in_ready), 128'd1);
    tick;
    bus.state_in = bp[2];
    #1;
    check("bp_full_not_ready", 128'(bus.in_ready), 128'd0);
    for (int i = 0; i < 5; i++) begin
      tick;
      check("bp_stall_valid", 128'(bus.out_valid), 128'd1);
      check("bp_stall_hold", bus.state_out, bp[0]);
      check("bp_stall_ready", 128'(bus.in_ready), 128'd0);
    end
    bus.out_ready = 1'b1;
    #1;
    check("bp_release_ready", 128'(bus.in_ready), 128'd1);
    sent = 2;
    rcv  = 0;
    for (int cyc = 0; cyc < 20 && rcv < 4; cyc++) begin
      #1;
      acc = bus.in_valid && bus.in_ready;
      con = bus.out_valid && bus.out_ready;
      if (con) begin
        check("bp_order", bus.state_out, bp[rcv]);
        rcv++;
      end
      tick;
      if (acc) begin
        sent++;
        if (sent < 4) bus.state_in = bp[sent];
        else bus.in_valid = 1'b0;
      end
    end
    check("bp_all_out", 128'(rcv), 128'd4);
    #1;
    check("bp_no_dup", 128'(bus.out_valid), 128'd0);
    exp_cnt += 4;
    check("bp_count", 128'(bus.blk_count), 128'(exp_cnt));

    // Full rate: the all-c6 state is a MixColumns fixed point, so output is c6 ^ key.
    bus.last_round = 1'b0;
    bus.state_in   = {16{8'hc6}};
    bus.out_ready  = 1'b1;
    for (int i = 0; i < 8; i++) begin
      k = 8'(8'h10 * i + 8'h05);
      tp_exp[i] = {16{8'hc6 ^ k}};
    end
    for (int i = 0; i < 8; i++) begin
      k = 8'(8'h10 * i + 8'h05);
      bus.round_key = {16{k}};
      bus.in_valid  = 1'b1;
      #1;
      check("tp_in_ready", 128'(bus.in_ready), 128'd1);
      tick;
      check("tp_out_valid", 128'(bus.out_valid), (i >= 1) ? 128'd1 : 128'd0);
      if (i >= 1) check("tp_state", bus.state_out, tp_exp[i-1]);
    end
    bus.in_valid = 1'b0;
    tick;
    check("tp_last_valid", 128'(bus.out_valid), 128'd1);
    check("tp_last_state", bus.state_out, tp_exp[7]);
    tick;
    check("tp_drained", 128'(bus.out_valid), 128'd0);
    exp_cnt += 8;
    check("tp_count", 128'(bus.blk_count), 128'(exp_cnt));

    // Reset with both stages holding data.
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.state_in  = {16{8'h55}};
    bus.round_key = '0;
    tick;
    bus.state_in = {16{8'h66}};
    tick;
    bus.in_valid = 1'b0;
    #1;
    check("mr_full_valid", 128'(bus.out_valid), 128'd1);
    check("mr_full_ready", 128'(bus.in_ready), 128'd0);
    rst_n = 1'b0;
    tick;
    check("mr_out_valid", 128'(bus.out_valid), 128'd0);
    check("mr_state_out", bus.state_out, 128'd0);
    check("mr_blk_count", 128'(bus.blk_count), 128'd0);
    check("mr_in_ready", 128'(bus.in_ready), 128'd1);
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    exp_cnt = 0;
    for (int i = 0; i < 3; i++) begin
      tick;
      check("mr_no_stale", 128'(bus.out_valid), 128'd0);
    end
    send_one("mr_recover", {16{8'hc6}}, {16{8'hff}}, 1'b0, {16{8'h39}});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
